// File: rtl/clock_to_bcd_pkg.sv
// Shared constants and types for the clock_to_bcd digit decoder.
// Holds the digit-select codes, the default blank code and the BCD digit type.
package clock_to_bcd_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam logic [3:0] SEL_HOUR_TENS  = 4'd0;
   localparam logic [3:0] SEL_HOUR_UNITS = 4'd1;
   localparam logic [3:0] SEL_MIN_TENS   = 4'd2;
   localparam logic [3:0] SEL_MIN_UNITS  = 4'd3;
   localparam logic [3:0] SEL_SEC_TENS   = 4'd4;
   localparam logic [3:0] SEL_SEC_UNITS  = 4'd5;

   localparam bcd_digit_t DEFAULT_BLANK_CODE = 4'hF;

   // Even selects address a tens digit, odd selects a units digit.
   function automatic logic is_tens_select(input logic [3:0] sel);
      return ~sel[0];
   endfunction

endpackage

// File: rtl/clock_to_bcd_binary_to_bcd.sv
// binary_to_bcd: splits a 6-bit binary value (0-63) into tens and units BCD digits.
// Pure combinational; tens ranges 0-6, units always 0-9.
module binary_to_bcd
   import clock_to_bcd_pkg::*;
(
   input  logic [5:0] bin,
   output bcd_digit_t tens,
   output bcd_digit_t units
);

   // Only the low nibble of (tens*10) is kept: the remainder is below 10, so
   // the upper bits of the subtraction are always zero and need not be built.
   logic [3:0] base_lo;

   always_comb begin
      tens    = 4'd0;
      base_lo = 4'd0;
      if (bin >= 6'd60) begin
         tens    = 4'd6;
         base_lo = 4'd12;
      end else if (bin >= 6'd50) begin
         tens    = 4'd5;
         base_lo = 4'd2;
      end else if (bin >= 6'd40) begin
         tens    = 4'd4;
         base_lo = 4'd8;
      end else if (bin >= 6'd30) begin
         tens    = 4'd3;
         base_lo = 4'd14;
      end else if (bin >= 6'd20) begin
         tens    = 4'd2;
         base_lo = 4'd4;
      end else if (bin >= 6'd10) begin
         tens    = 4'd1;
         base_lo = 4'd10;
      end
      units = bin[3:0] - base_lo;
   end

endmodule

// File: rtl/clock_to_bcd.sv
// clock_to_bcd: picks one digit of an HH:MM:SS time and outputs it as BCD plus its decimal point.
// Define CLOCK_TO_BCD_OUTREG_EN to register the outputs (one cycle latency, async reset to 0).
module clock_to_bcd
   import clock_to_bcd_pkg::*;
#(
   parameter bcd_digit_t BLANK_CODE = DEFAULT_BLANK_CODE
)(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [4:0] i_hours,
   input  logic [5:0] i_minutes,
   input  logic [5:0] i_seconds,
   input  logic [5:0] i_dp,
   input  logic [3:0] i_seg_select,
   output logic [3:0] o_bcd,
   output logic       o_dp
);

   logic [5:0] field;
   bcd_digit_t tens;
   bcd_digit_t units;
   bcd_digit_t bcd_next;
   logic       dp_next;

   always_comb begin
      field = 6'd0;
      case (i_seg_select)
         SEL_HOUR_TENS, SEL_HOUR_UNITS: field = {1'b0, i_hours};
         SEL_MIN_TENS,  SEL_MIN_UNITS:  field = i_minutes;
         SEL_SEC_TENS,  SEL_SEC_UNITS:  field = i_seconds;
         default:                       field = 6'd0;
      endcase
   end

   binary_to_bcd u_binary_to_bcd (
      .bin   (field),
      .tens  (tens),
      .units (units)
   );

   always_comb begin
      bcd_next = BLANK_CODE;
      dp_next  = 1'b0;
      if (i_seg_select <= SEL_SEC_UNITS) begin
         bcd_next = is_tens_select(i_seg_select) ? tens : units;
         dp_next  = i_dp[i_seg_select[2:0]];
      end
   end

`ifdef CLOCK_TO_BCD_OUTREG_EN
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_bcd <= 4'd0;
         o_dp  <= 1'b0;
      end else begin
         o_bcd <= bcd_next;
         o_dp  <= dp_next;
      end
   end
`else
   // Clock and reset are deliberately ignored when the outputs are combinational.
   logic unused_clk_rst;
   assign unused_clk_rst = i_clk ^ i_rst;

   assign o_bcd = bcd_next;
   assign o_dp  = dp_next;
`endif

endmodule

// File: tb/tb_clock_to_bcd.sv
// Self-checking bench for clock_to_bcd; expectations queued at stimulus time and popped at the sample point.
// Follows CLOCK_TO_BCD_OUTREG_EN to pick the output latency and reset behaviour it expects.
module tb_clock_to_bcd;

`ifdef CLOCK_TO_BCD_OUTREG_EN
   localparam bit REG_BUILD = 1'b1;
`else
   localparam bit REG_BUILD = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic [4:0] hours;
   logic [5:0] minutes;
   logic [5:0] seconds;
   logic [5:0] dp;
   logic [3:0] sel;
   logic [3:0] o_bcd;
   logic       o_dp;

   typedef struct {
      logic [3:0] bcd;
      logic       dp;
      string      tag;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   clock_to_bcd dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_hours      (hours),
      .i_minutes    (minutes),
      .i_seconds    (seconds),
      .i_dp         (dp),
      .i_seg_select (sel),
      .o_bcd        (o_bcd),
      .o_dp         (o_dp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation still running, expected to have finished");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference behaviour written straight from the digit definitions.
   function automatic exp_t model(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                                  input logic [5:0] d, input logic [3:0] sl);
      exp_t e;
      int   v;
      e.bcd = 4'hF;
      e.dp  = 1'b0;
      e.tag = "";
      if (sl <= 4'd5) begin
         v = (sl < 4'd2) ? int'(h) : (sl < 4'd4) ? int'(m) : int'(s);
         e.bcd = (sl[0] == 1'b0) ? 4'(v / 10) : 4'(v % 10);
         e.dp  = d[sl];
      end
      return e;
   endfunction

   // Drive one vector just after the rising edge and queue what it should produce.
   task automatic drive_push(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                             input logic [5:0] d, input logic [3:0] sl,
                             input logic [3:0] eb, input logic ed, input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      hours = h; minutes = m; seconds = s; dp = d; sel = sl;
      e.bcd = eb; e.dp = ed; e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic wait_output();
      if (REG_BUILD) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [3:0] rb;
      logic       rd;
      rb = REG_BUILD ? 4'd0 : 4'd2;
      rd = REG_BUILD ? 1'b0 : 1'b1;
      rst = 1'b1;
      hours = 5'd12; minutes = 6'd0; seconds = 6'd0; dp = 6'b000010; sel = 4'd1;
      repeat (2) @(posedge clk);
      #2;
      checks++;
      if (o_bcd !== rb || o_dp !== rd) begin
         errors++;
         $display("[TB] FAIL reset_held: bcd=%0h dp=%0b expected bcd=%0h dp=%0b", o_bcd, o_dp, rb, rd);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (o_bcd !== rb || o_dp !== rd) begin
         errors++;
         $display("[TB] FAIL reset_release: bcd=%0h dp=%0b expected bcd=%0h dp=%0b", o_bcd, o_dp, rb, rd);
      end
      @(posedge clk);
      #1;
      checks++;
      if (o_bcd !== 4'd2 || o_dp !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_first_edge: bcd=%0h dp=%0b expected bcd=2 dp=1", o_bcd, o_dp);
      end
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (o_bcd !== rb || o_dp !== rd) begin
         errors++;
         $display("[TB] FAIL reset_midcycle: bcd=%0h dp=%0b expected bcd=%0h dp=%0b", o_bcd, o_dp, rb, rd);
      end
      #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (o_bcd !== rb || o_dp !== rd) begin
         errors++;
         $display("[TB] FAIL reset_before_edge: bcd=%0h dp=%0b expected bcd=%0h dp=%0b", o_bcd, o_dp, rb, rd);
      end
      @(posedge clk);
      #1;
      checks++;
      if (o_bcd !== 4'd2 || o_dp !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_after_edge: bcd=%0h dp=%0b expected bcd=2 dp=1", o_bcd, o_dp);
      end
   endtask

   // Steps select 0-5 one per cycle; expected digits packed with select 0 in the top nibble.
   task automatic test_digits(input string name, input logic [4:0] h, input logic [5:0] m,
                              input logic [5:0] s, input logic [5:0] d, input logic [23:0] digits,
                              input logic [5:0] dps);
      exp_t got;
      for (int i = 0; i < 6; i++) begin
         drive_push(h, m, s, d, 4'(i), digits[23 - 4*i -: 4], dps[i], $sformatf("%s_sel%0d", name, i));
         wait_output();
         got = sb.pop_front();
         checks++;
         if (o_bcd !== got.bcd) begin
            errors++;
            $display("[TB] FAIL %s bcd: got %0h expected %0h", got.tag, o_bcd, got.bcd);
         end
         checks++;
         if (o_dp !== got.dp) begin
            errors++;
            $display("[TB] FAIL %s dp: got %0b expected %0b", got.tag, o_dp, got.dp);
         end
      end
   endtask

   task automatic test_blank();
      logic [3:0] sels [4];
      logic [5:0] dps  [4];
      exp_t       got;
      sels = '{4'd6, 4'd15, 4'd7, 4'd10};
      dps  = '{6'b010100, 6'b010100, 6'b111111, 6'b111111};
      for (int i = 0; i < 4; i++) begin
         drive_push(5'd23, 6'd59, 6'd59, dps[i], sels[i], 4'hF, 1'b0, $sformatf("blank_sel%0d", sels[i]));
         wait_output();
         got = sb.pop_front();
         checks++;
         if (o_bcd !== got.bcd || o_dp !== got.dp) begin
            errors++;
            $display("[TB] FAIL %s: got bcd=%0h dp=%0b expected bcd=%0h dp=%0b",
                     got.tag, o_bcd, o_dp, got.bcd, got.dp);
         end
      end
   endtask

   task automatic test_random();
      logic [4:0] h;
      logic [5:0] m, s, d;
      logic [3:0] sl;
      exp_t       e, got;
      for (int i = 0; i < 60; i++) begin
         h  = 5'($urandom_range(0, 31));
         m  = 6'($urandom_range(0, 63));
         s  = 6'($urandom_range(0, 63));
         d  = 6'($urandom_range(0, 63));
         sl = 4'($urandom_range(0, 15));
         e  = model(h, m, s, d, sl);
         drive_push(h, m, s, d, sl, e.bcd, e.dp,
                    $sformatf("rand%0d h=%0d m=%0d s=%0d sel=%0d", i, h, m, s, sl));
         wait_output();
         got = sb.pop_front();
         checks++;
         if (o_bcd !== got.bcd || o_dp !== got.dp) begin
            errors++;
            $display("[TB] FAIL %s: got bcd=%0h dp=%0b expected bcd=%0h dp=%0b",
                     got.tag, o_bcd, o_dp, got.bcd, got.dp);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      hours = '0; minutes = '0; seconds = '0; dp = '0; sel = '0;
      $display("[TB] start, registered build = %0b", REG_BUILD);
      test_reset();
      test_digits("zero",   5'd0,  6'd0,  6'd0,  6'b000000, 24'h000000, 6'b000000);
      test_digits("t12_30", 5'd12, 6'd30, 6'd59, 6'b000000, 24'h123059, 6'b000000);
      test_digits("t23_15", 5'd23, 6'd15, 6'd30, 6'b000000, 24'h231530, 6'b000000);
      test_digits("dp",     5'd12, 6'd30, 6'd59, 6'b010100, 24'h123059, 6'b010100);
      test_digits("range",  5'd31, 6'd63, 6'd60, 6'b101011, 24'h316360, 6'b101011);
      test_blank();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/clock_to_bcd.md
CLOCK_TO_BCD -- requirements
Module: clock_to_bcd

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named i_clk and i_rst.
REQ-002 Parameter BLANK_CODE, default 4'hF: value driven on o_bcd for an invalid digit select.
REQ-003 i_clk  input  1  block clock; rising edge only.
REQ-004 i_rst  input  1  asynchronous active-high reset.
REQ-005 i_hours  input  5  binary hours, 0-23 nominal.
REQ-006 i_minutes  input  6  binary minutes, 0-59 nominal.
REQ-007 i_seconds  input  6  binary seconds, 0-59 nominal.
REQ-008 i_dp  input  6  per-digit decimal point; bit n belongs to digit n.
REQ-009 i_seg_select  input  4  digit select; 0 = hours tens ... 5 = seconds units.
REQ-010 o_bcd  output  4  BCD digit for the selected position.
REQ-011 o_dp  output  1  decimal point for the selected position.

Function
REQ-012 Select 0 SHALL give i_hours/10; select 1 i_hours%10; select 2 i_minutes/10; select 3 i_minutes%10; select 4 i_seconds/10; select 5 i_seconds%10.
REQ-013 o_dp SHALL equal i_dp[i_seg_select] for selects 0-5.
REQ-014 Selects 6-15 SHALL drive o_bcd = BLANK_CODE and o_dp = 0.
REQ-015 Without the configuration macro, o_bcd and o_dp SHALL be purely combinational from the inputs, with zero latency and no dependence on i_clk.
REQ-016 Out-of-range inputs SHALL still be converted arithmetically: hours 24-31 give tens 2-3; minutes/seconds 60-63 give tens 6. The block SHALL NOT saturate or flag them.
REQ-017 The conversion SHALL be exact integer division and modulo by 10; each output digit SHALL be in the range 0-9 for every select 0-5.
REQ-018 Changing the inputs or the select SHALL settle the output within the same cycle; a value applied at a rising edge SHALL be valid by the following falling edge.

Reset
REQ-019 In the combinational build, i_rst SHALL have no effect on the outputs.
REQ-020 In the registered build, i_rst high SHALL asynchronously force o_bcd = 0 and o_dp = 0.
REQ-021 In the registered build, the outputs SHALL hold those values until the first rising i_clk edge after i_rst is released.

Configuration
REQ-022 Macro CLOCK_TO_BCD_OUTREG_EN: when defined, o_bcd and o_dp SHALL be registered on the rising edge of i_clk, giving exactly one cycle of latency from inputs and select to outputs.
REQ-023 When CLOCK_TO_BCD_OUTREG_EN is undefined, no flops SHALL be inferred and REQ-015 SHALL apply.
REQ-024 Function (REQ-012 to REQ-017) SHALL be identical in both builds apart from latency and reset.

Structure
REQ-025 Shared package clock_to_bcd_pkg SHALL hold:
- digit-select constants SEL_HOUR_TENS through SEL_SEC_UNITS (0-5);
- the default blank code 4'hF;
- a bcd_digit_t 4-bit typedef.
REQ-026 The block SHALL first multiplex the field selected by i_seg_select, zero-extended to 6 bits.
REQ-027 A single sub-module binary_to_bcd SHALL convert that 6-bit value (0-63) to a tens digit and a units digit.
REQ-028 The output multiplexer SHALL then pick the tens or units digit from binary_to_bcd according to the select.

Verification
REQ-029 Combinational build: hours 0, minutes 0, seconds 0; step select 0-5, one per cycle, checking each at the falling edge -> o_bcd = 0,0,0,0,0,0.
REQ-030 Hours 12, minutes 30, seconds 59; step select 0-5 -> o_bcd = 1,2,3,0,5,9.
REQ-031 Hours 23, minutes 15, seconds 30; step select 0-5 -> o_bcd = 2,3,1,5,3,0.
REQ-032 i_dp = 6'b010100; step select 0-5 -> o_dp = 0,0,1,0,1,0. Selects 6 and 15 -> o_bcd = 4'hF, o_dp = 0.
REQ-033 Hours 31, minutes 63, seconds 60; step select 0-5 -> o_bcd = 3,1,6,3,6,0.
REQ-034 Registered build:
- assert i_rst mid-cycle -> outputs 0 immediately;
- release i_rst, apply select 1 with hours 12 -> o_bcd = 2 after the next rising edge, not before.
